// File: rtl/sha_const.sv
// Shared SHA-2 constants: round constants, initial hash values and FSM state encoding.
// Both families live here; the core picks by word width at elaboration.
package sha_const;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_e;

    localparam logic [31:0] K256 [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam logic [63:0] K512 [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

    localparam logic [31:0] IV224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                          32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
    localparam logic [31:0] IV256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [63:0] IV384 [8] = '{64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
                                          64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
    localparam logic [63:0] IV512 [8] = '{64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                                          64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

    // 32-bit family values come back zero-extended; callers slice to their width.
    function automatic logic [63:0] k_const(input int w, input logic [6:0] t);
        if (w == 32) return {32'h0, K256[t[5:0]]};
        return K512[t];
    endfunction

    function automatic logic [63:0] iv_word(input int w, input logic mode, input logic [2:0] i);
        if (w == 32) return {32'h0, mode ? IV224[i] : IV256[i]};
        return mode ? IV384[i] : IV512[i];
    endfunction

endpackage

// File: rtl/sha_2_schedule.sv
// Rolling 16-word message schedule window; w_t is always the word for the current round.
module sha_2_schedule #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  load,
    input  logic                  advance,
    input  logic [16*WIDTH-1:0]   data,
    output logic [WIDTH-1:0]      w_t
);
    localparam int R0A = (WIDTH == 32) ? 7  : 1;
    localparam int R0B = (WIDTH == 32) ? 18 : 8;
    localparam int R0S = (WIDTH == 32) ? 3  : 7;
    localparam int R1A = (WIDTH == 32) ? 17 : 19;
    localparam int R1B = (WIDTH == 32) ? 19 : 61;
    localparam int R1S = (WIDTH == 32) ? 10 : 6;

    logic [WIDTH-1:0] win [16];
    logic [WIDTH-1:0] w_new;

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int n);
        return (x >> n) | (x << (WIDTH - n));
    endfunction

    // Window holds W_t..W_t+15, so the next word is W_t+16.
    always_comb begin
        w_new = (rotr(win[14], R1A) ^ rotr(win[14], R1B) ^ (win[14] >> R1S)) + win[9]
              + (rotr(win[1], R0A) ^ rotr(win[1], R0B) ^ (win[1] >> R0S)) + win[0];
    end

    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 16; i++) win[i] <= data[i*WIDTH +: WIDTH];
        end else if (advance) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= w_new;
        end
    end

    assign w_t = win[0];

endmodule

// File: rtl/sha_2_core.sv
// SHA-224/256/384/512 block compression engine, one round per clock, with chaining
// across blocks of a message and a held, optionally truncated Hash output.
module sha_2_core
    import sha_const::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [16*WIDTH-1:0]   Data,
    input  logic [63:0]           Index,
    input  logic                  Mode,
    input  logic                  Enable,
    output logic                  Busy,
    output logic                  Ready,
    output logic [8*WIDTH-1:0]    Hash
);
    localparam int ROUNDS     = (WIDTH == 32) ? 64 : 80;
    localparam logic [6:0] T_LAST = 7'(ROUNDS - 1);
    localparam int TRUNC_FROM = (WIDTH == 32) ? 7 : 6;

    localparam int S0A = (WIDTH == 32) ? 2  : 28;
    localparam int S0B = (WIDTH == 32) ? 13 : 34;
    localparam int S0C = (WIDTH == 32) ? 22 : 39;
    localparam int S1A = (WIDTH == 32) ? 6  : 14;
    localparam int S1B = (WIDTH == 32) ? 11 : 18;
    localparam int S1C = (WIDTH == 32) ? 25 : 41;

    generate
        if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
            $error("sha_2_core: WIDTH must be 32 or 64");
        end
    endgenerate

    state_e            state, state_next;
    logic [6:0]        t;
    logic              mode_q;
    logic [WIDTH-1:0]  wr [8];
    logic [WIDTH-1:0]  hc [8];
    logic [WIDTH-1:0]  h_load [8];
    logic [WIDTH-1:0]  h_rst [8];
    logic [WIDTH-1:0]  h_sum [8];
    logic [WIDTH-1:0]  w_t, k_t, t1, t2, s0, s1, ch, maj;
    logic              accept;

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int n);
        return (x >> n) | (x << (WIDTH - n));
    endfunction

    function automatic logic [WIDTH-1:0] iv_w(input logic mode, input int i);
        logic [63:0] v;
        v = iv_word(WIDTH, mode, 3'(i));
        return v[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] k_w(input logic [6:0] idx);
        logic [63:0] v;
        v = k_const(WIDTH, idx);
        return v[WIDTH-1:0];
    endfunction

    assign accept = (state == IDLE) && Enable;
    assign Busy   = (state != IDLE);

    sha_2_schedule #(.WIDTH(WIDTH)) u_sched (
        .clk     (clk),
        .load    (accept),
        .advance (state == ROUND),
        .data    (Data),
        .w_t     (w_t)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Enable) state_next = ROUND;
            ROUND:   if (t == T_LAST) state_next = FINAL;
            FINAL:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Index==0 starts a new message from the IV; otherwise continue the chain.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            h_rst[i]  = iv_w(1'b0, i);
            h_load[i] = (Index == '0) ? iv_w(Mode, i) : hc[i];
            h_sum[i]  = hc[i] + wr[i];
        end
    end

    always_comb begin
        s1  = rotr(wr[4], S1A) ^ rotr(wr[4], S1B) ^ rotr(wr[4], S1C);
        ch  = (wr[4] & wr[5]) ^ (~wr[4] & wr[6]);
        s0  = rotr(wr[0], S0A) ^ rotr(wr[0], S0B) ^ rotr(wr[0], S0C);
        maj = (wr[0] & wr[1]) ^ (wr[0] & wr[2]) ^ (wr[1] & wr[2]);
        k_t = k_w(t);
        t1  = wr[7] + s1 + ch + k_t + w_t;
        t2  = s0 + maj;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            t      <= '0;
            mode_q <= 1'b0;
            Ready  <= 1'b0;
            Hash   <= '0;
            for (int i = 0; i < 8; i++) begin
                hc[i] <= h_rst[i];
                wr[i] <= '0;
            end
        end else begin
            Ready <= 1'b0;
            case (state)
                IDLE: if (Enable) begin
                    t <= '0;
                    if (Index == '0) mode_q <= Mode;
                    for (int i = 0; i < 8; i++) begin
                        hc[i] <= h_load[i];
                        wr[i] <= h_load[i];
                    end
                end
                ROUND: begin
                    t     <= t + 7'd1;
                    wr[0] <= t1 + t2;
                    wr[1] <= wr[0];
                    wr[2] <= wr[1];
                    wr[3] <= wr[2];
                    wr[4] <= wr[3] + t1;
                    wr[5] <= wr[4];
                    wr[6] <= wr[5];
                    wr[7] <= wr[6];
                end
                FINAL: begin
                    t     <= '0;
                    Ready <= 1'b1;
                    for (int i = 0; i < 8; i++) begin
                        hc[i] <= h_sum[i];
                        Hash[(7-i)*WIDTH +: WIDTH] <= (mode_q && i >= TRUNC_FROM) ? '0 : h_sum[i];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_2_core.sv
// Scoreboard bench for sha_2_core at both widths against a textbook SHA-2 model.
module tb_sha_2_core;
    import sha_const::*;

    typedef logic [15:0][63:0] blk_t;
    typedef logic [7:0][63:0]  hv_t;
    typedef struct { logic [511:0] hash; int cyc; } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic          rst32, en32, mode32, busy32, rdy32;
    logic [63:0]   idx32;
    logic [511:0]  data32;
    logic [255:0]  hash32;
    logic          rst64, en64, mode64, busy64, rdy64;
    logic [63:0]   idx64;
    logic [1023:0] data64;
    logic [511:0]  hash64;

    sha_2_core #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst32), .Data(data32), .Index(idx32), .Mode(mode32),
                                    .Enable(en32), .Busy(busy32), .Ready(rdy32), .Hash(hash32));
    sha_2_core #(.WIDTH(64)) dut64 (.clk(clk), .rst(rst64), .Data(data64), .Index(idx64), .Mode(mode64),
                                    .Enable(en64), .Busy(busy64), .Ready(rdy64), .Hash(hash64));

    int   errors = 0, checks = 0;
    exp_t q32[$], q64[$];
    exp_t e32, e64;
    hv_t  mh [2];
    logic mm [2];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] msk(input int w);
        return (w == 32) ? 64'h0000_0000_ffff_ffff : 64'hffff_ffff_ffff_ffff;
    endfunction
    function automatic logic [63:0] rr(input logic [63:0] x, input int n, input int w);
        return ((x >> n) | (x << (w - n))) & msk(w);
    endfunction
    function automatic logic [63:0] bs0(input logic [63:0] x, input int w);
        return (w == 32) ? rr(x,2,w) ^ rr(x,13,w) ^ rr(x,22,w) : rr(x,28,w) ^ rr(x,34,w) ^ rr(x,39,w);
    endfunction
    function automatic logic [63:0] bs1(input logic [63:0] x, input int w);
        return (w == 32) ? rr(x,6,w) ^ rr(x,11,w) ^ rr(x,25,w) : rr(x,14,w) ^ rr(x,18,w) ^ rr(x,41,w);
    endfunction
    function automatic logic [63:0] ss0(input logic [63:0] x, input int w);
        return (w == 32) ? rr(x,7,w) ^ rr(x,18,w) ^ (x >> 3) : rr(x,1,w) ^ rr(x,8,w) ^ (x >> 7);
    endfunction
    function automatic logic [63:0] ss1(input logic [63:0] x, input int w);
        return (w == 32) ? rr(x,17,w) ^ rr(x,19,w) ^ (x >> 10) : rr(x,19,w) ^ rr(x,61,w) ^ (x >> 6);
    endfunction

    function automatic hv_t compress(input int w, input hv_t h, input blk_t m);
        logic [63:0] W [80];
        logic [63:0] a, b, c, d, e, f, g, hh, t1, t2, mk;
        hv_t r;
        int n;
        mk = msk(w);
        n  = (w == 32) ? 64 : 80;
        for (int i = 0; i < 16; i++) W[i] = m[i] & mk;
        for (int i = 16; i < n; i++) W[i] = (ss1(W[i-2], w) + W[i-7] + ss0(W[i-15], w) + W[i-16]) & mk;
        a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
        for (int i = 0; i < n; i++) begin
            t1 = (hh + bs1(e, w) + (((e & f) ^ (~e & g)) & mk) + k_const(w, 7'(i)) + W[i]) & mk;
            t2 = (bs0(a, w) + ((a & b) ^ (a & c) ^ (b & c))) & mk;
            hh = g; g = f; f = e; e = (d + t1) & mk;
            d = c; c = b; b = a; a = (t1 + t2) & mk;
        end
        r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e; r[5] = f; r[6] = g; r[7] = hh;
        for (int i = 0; i < 8; i++) r[i] = (r[i] + h[i]) & mk;
        return r;
    endfunction

    function automatic hv_t ivv(input int w, input logic mode);
        hv_t r;
        for (int i = 0; i < 8; i++) r[i] = iv_word(w, mode, 3'(i));
        return r;
    endfunction

    function automatic logic [511:0] to_hash(input int w, input hv_t h, input logic mode);
        logic [511:0] r = '0;
        for (int i = 0; i < 8; i++) begin
            if (w == 32) r[(7-i)*32 +: 32] = (mode && i == 7) ? 32'h0 : h[i][31:0];
            else         r[(7-i)*64 +: 64] = (mode && i >= 6) ? 64'h0 : h[i];
        end
        return r;
    endfunction

    function automatic logic [1023:0] pack(input int w, input blk_t m);
        logic [1023:0] r = '0;
        for (int i = 0; i < 16; i++) begin
            if (w == 32) r[i*32 +: 32] = m[i][31:0];
            else         r[i*64 +: 64] = m[i];
        end
        return r;
    endfunction

    function automatic blk_t rand_blk(input int w);
        blk_t m;
        for (int i = 0; i < 16; i++) m[i] = (w == 32) ? {32'h0, $urandom} : {$urandom, $urandom};
        return m;
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) if (rst32 && rdy32) begin
        if (q32.size() == 0) begin
            checks++; errors++;
            $display("FAIL ready32_spurious: got Ready=1 want no pulse");
        end else begin
            e32 = q32.pop_front();
            chk("hash32", {256'h0, hash32}, e32.hash);
            chk("latency32", 512'(cyc), 512'(e32.cyc));
        end
    end

    always @(negedge clk) if (rst64 && rdy64) begin
        if (q64.size() == 0) begin
            checks++; errors++;
            $display("FAIL ready64_spurious: got Ready=1 want no pulse");
        end else begin
            e64 = q64.pop_front();
            chk("hash64", hash64, e64.hash);
            chk("latency64", 512'(cyc), 512'(e64.cyc));
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input int w, input blk_t m, input logic [63:0] idx, input logic mode,
                         input logic use_kat, input logic [511:0] kat, input logic hold);
        exp_t e;
        logic [1023:0] d;
        int s;
        s = (w == 64) ? 1 : 0;
        d = pack(w, m);
        @(negedge clk);
        if (w == 32) begin data32 = d[511:0]; idx32 = idx; mode32 = mode; en32 = 1'b1; end
        else         begin data64 = d;        idx64 = idx; mode64 = mode; en64 = 1'b1; end
        if (idx == 0) begin mh[s] = ivv(w, mode); mm[s] = mode; end
        mh[s] = compress(w, mh[s], m);
        @(posedge clk); #1;
        e.hash = use_kat ? kat : to_hash(w, mh[s], mm[s]);
        e.cyc  = cyc + ((w == 32) ? 65 : 81);
        if (w == 32) begin
            if (!hold) en32 = 1'b0;
            q32.push_back(e);
            chk("busy32_after_accept", 512'(busy32), 512'(1));
        end else begin
            if (!hold) en64 = 1'b0;
            q64.push_back(e);
            chk("busy64_after_accept", 512'(busy64), 512'(1));
        end
    endtask

    task automatic wait_idle(input int w);
        int k = 0;
        while (((w == 32) ? (busy32 || q32.size() != 0) : (busy64 || q64.size() != 0)) && k < 400) begin
            @(negedge clk); k++;
        end
        chk((w == 32) ? "idle32_timeout" : "idle64_timeout", 512'(k >= 400), 512'(0));
    endtask

    blk_t abc32, abc64, two0, two1, rb;
    localparam logic [511:0] KAT256 = 512'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [511:0] KAT224 = 512'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
    localparam logic [511:0] KAT512 = 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;
    localparam logic [511:0] KAT2B  = 512'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [447:0] MSG2   = 448'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071;

    initial begin
        int c0;
        exp_t e;
        abc32 = '0; abc32[0] = 64'h61626380;          abc32[15] = 64'h18;
        abc64 = '0; abc64[0] = 64'h6162638000000000;  abc64[15] = 64'h18;
        two0 = '0; two1 = '0;
        for (int i = 0; i < 14; i++) two0[i] = {32'h0, MSG2[(13-i)*32 +: 32]};
        two0[14] = 64'h80000000; two1[15] = 64'h1c0;
        mh[0] = ivv(32, 1'b0); mh[1] = ivv(64, 1'b0); mm[0] = 1'b0; mm[1] = 1'b0;

        rst32 = 0; rst64 = 0; en32 = 0; en64 = 0; mode32 = 0; mode64 = 0;
        idx32 = '0; idx64 = '0; data32 = '0; data64 = '0;
        repeat (2) @(posedge clk); #1;
        chk("reset_busy32", 512'(busy32), 512'(0));
        chk("reset_ready32", 512'(rdy32), 512'(0));
        chk("reset_hash32", {256'h0, hash32}, 512'h0);
        chk("reset_hash64", hash64, 512'h0);
        @(negedge clk); rst32 = 1; rst64 = 1;

        // Wide family: known answer, then random chained blocks.
        issue(64, abc64, 64'd0, 1'b0, 1'b1, KAT512, 1'b0); wait_idle(64);
        for (int i = 0; i < 3; i++) begin
            rb = rand_blk(64);
            issue(64, rb, (i == 0) ? 64'd0 : 64'(i), $urandom_range(0, 1), 1'b0, '0, 1'b0);
            wait_idle(64);
        end

        // Narrow family known answers.
        issue(32, abc32, 64'd0, 1'b0, 1'b1, KAT256, 1'b0); wait_idle(32);
        issue(32, abc32, 64'd0, 1'b1, 1'b1, KAT224, 1'b0); wait_idle(32);

        // Two-block message, Enable held through the first Ready, Mode flipped on block 2.
        issue(32, two0, 64'd0, 1'b0, 1'b0, '0, 1'b1);
        c0 = cyc;
        data32 = pack(32, two1)[511:0]; idx32 = 64'd1; mode32 = 1'b1;
        mh[0] = compress(32, mh[0], two1);
        e.hash = KAT2B; e.cyc = c0 + 66 + 65;
        q32.push_back(e);
        repeat (66) @(posedge clk); #1;
        en32 = 1'b0;
        chk("busy32_b2b_accept", 512'(busy32), 512'(1));
        wait_idle(32);

        // Enable pulse while busy must be ignored.
        issue(32, abc32, 64'd0, 1'b0, 1'b1, KAT256, 1'b0);
        repeat (10) @(negedge clk);
        rb = rand_blk(32);
        data32 = pack(32, rb)[511:0]; idx32 = 64'd0; mode32 = 1'b1; en32 = 1'b1;
        @(negedge clk); en32 = 1'b0;
        wait_idle(32);
        repeat (5) @(negedge clk);

        // Reset mid-block aborts it and restores the mode-0 IV chain.
        issue(32, abc32, 64'd0, 1'b1, 1'b1, KAT224, 1'b0);
        repeat (30) @(negedge clk);
        rst32 = 0;
        @(posedge clk); #1;
        chk("midrst_busy32", 512'(busy32), 512'(0));
        chk("midrst_ready32", 512'(rdy32), 512'(0));
        chk("midrst_hash32", {256'h0, hash32}, 512'h0);
        q32.delete();
        mh[0] = ivv(32, 1'b0); mm[0] = 1'b0;
        @(negedge clk); rst32 = 1;
        repeat (80) @(negedge clk);
        rb = rand_blk(32);
        issue(32, rb, 64'd5, 1'b1, 1'b0, '0, 1'b0); wait_idle(32);
        issue(32, abc32, 64'd0, 1'b0, 1'b1, KAT256, 1'b0); wait_idle(32);

        // Random blocks with random new-message/continue decisions.
        for (int i = 0; i < 6; i++) begin
            rb = rand_blk(32);
            issue(32, rb, ($urandom_range(0, 2) == 0) ? 64'd0 : {$urandom, $urandom} | 64'd1,
                  $urandom_range(0, 1), 1'b0, '0, 1'b0);
            wait_idle(32);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("q32_drained", 512'(q32.size()), 512'(0));
        chk("q64_drained", 512'(q64.size()), 512'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
